// File: rtl/tv_seq_pkg.sv
// Shared types and constants for the test-vector sequencer.
//   tv_seq_state_e             : sequencer FSM states
//   tv_word_s                  : one vector ROM word {stim, exp}, stim in the MSBs
//   TV_SEQ_CYCLES_PER_VEC_BASE : fixed per-vector cost excluding DUT latency
package tv_seq_pkg;

   localparam int unsigned TV_IN_W                    = 8;
   localparam int unsigned TV_OUT_W                   = 8;
   localparam int unsigned TV_SEQ_CYCLES_PER_VEC_BASE = 3;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StApply,
      StWait,
      StCheck,
      StDone
   } tv_seq_state_e;

   typedef struct packed {
      logic [TV_IN_W-1:0]  stim;
      logic [TV_OUT_W-1:0] exp;
   } tv_word_s;

endpackage

// File: rtl/tv_seq_wait_cnt.sv
// Loadable down-counter that times the DUT latency wait.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   load     : load load_val (takes priority over counting)
//   load_val : number of extra wait cycles minus one
//   en       : counter is in its wait window
//   expired  : high for the single cycle in which the wait ends
module tv_seq_wait_cnt #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // Loading N-1 makes the wait last exactly N cycles of en.
   assign expired = en && (count == '0);

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: fetches {stim, exp} words from a vector ROM, drives the
// stimulus to a DUT, waits DUT_LAT cycles, compares the DUT output against the
// expected value and counts mismatches.
// Ports:
//   i_clk, i_reset   : clock and synchronous active-high reset
//   i_start          : start request, ignored while o_busy
//   i_num_vectors    : vectors to run, clamped to DEPTH, latched at start
//   o_mem_en/addr    : ROM read request (one cycle per vector)
//   i_mem_data       : ROM word, valid the cycle after o_mem_en
//   o_dut_in         : registered stimulus
//   i_dut_out        : DUT response
//   o_busy, o_done   : run in progress / run finished (level)
//   o_pass           : done with zero mismatches
//   o_err_count      : saturating mismatch count
//   o_fail_index     : index of the first mismatching vector
// Build option: define TV_SEQ_STOP_ON_ERR_EN to end the run at the first mismatch.
module tv_sequencer
   import tv_seq_pkg::*;
#(
   parameter int unsigned IN_W    = 8,
   parameter int unsigned OUT_W   = 8,
   parameter int unsigned DEPTH   = 128,
   parameter int unsigned ADDR_W  = $clog2(DEPTH),
   parameter int unsigned DUT_LAT = 1,
   parameter int unsigned ERR_W   = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [ADDR_W:0]         i_num_vectors,
   output logic                    o_mem_en,
   output logic [ADDR_W-1:0]       o_mem_addr,
   input  logic [IN_W+OUT_W-1:0]   i_mem_data,
   output logic [IN_W-1:0]         o_dut_in,
   input  logic [OUT_W-1:0]        i_dut_out,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_pass,
   output logic [ERR_W-1:0]        o_err_count,
   output logic [ADDR_W-1:0]       o_fail_index
);

`ifdef TV_SEQ_STOP_ON_ERR_EN
   localparam bit STOP_ON_ERR = 1'b1;
`else
   localparam bit STOP_ON_ERR = 1'b0;
`endif

   localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

   tv_seq_state_e    state;
   logic [ADDR_W-1:0] index;
   logic [ADDR_W:0]   n_q;
   logic [OUT_W-1:0]  exp_q;

   logic [ADDR_W:0]   n_start;
   logic [IN_W-1:0]   stim_field;
   logic [OUT_W-1:0]  exp_field;
   logic              mismatch;
   logic              last_vec;
   logic              finish_run;
   logic [ERR_W-1:0]  err_next;
   logic              wait_done;

   always_comb begin
      n_start    = (i_num_vectors > DEPTH_N) ? DEPTH_N : i_num_vectors;
      stim_field = i_mem_data[IN_W+OUT_W-1 -: IN_W];
      exp_field  = i_mem_data[OUT_W-1:0];
      mismatch   = (i_dut_out != exp_q);
      last_vec   = ({1'b0, index} == (n_q - 1'b1));
      finish_run = last_vec || (STOP_ON_ERR && mismatch);
      // Saturate instead of wrapping so a full counter can never read as a pass.
      err_next   = (&o_err_count) ? o_err_count : o_err_count + 1'b1;
   end

   // Wait timer only exists for a registered DUT; a combinational DUT goes
   // straight from APPLY to CHECK and never looks at wait_done.
   if (DUT_LAT > 0) begin : g_wait
      localparam int unsigned WAIT_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

      tv_seq_wait_cnt #(
         .WIDTH (WAIT_W)
      ) u_wait_cnt (
         .clk      (i_clk),
         .reset    (i_reset),
         .load     (state == StApply),
         .load_val (WAIT_W'(DUT_LAT - 1)),
         .en       (state == StWait),
         .expired  (wait_done)
      );
   end else begin : g_no_wait
      assign wait_done = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= StIdle;
         index        <= '0;
         n_q          <= '0;
         exp_q        <= '0;
         o_mem_en     <= 1'b0;
         o_mem_addr   <= '0;
         o_dut_in     <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_pass       <= 1'b0;
         o_err_count  <= '0;
         o_fail_index <= '0;
      end else begin
         case (state)
            StIdle, StDone: begin
               if (i_start) begin
                  n_q          <= n_start;
                  index        <= '0;
                  o_err_count  <= '0;
                  o_fail_index <= '0;
                  if (n_start == '0) begin
                     // Empty run: finish immediately as a trivial pass.
                     state  <= StDone;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                     o_pass <= 1'b1;
                  end else begin
                     state      <= StFetch;
                     o_busy     <= 1'b1;
                     o_done     <= 1'b0;
                     o_pass     <= 1'b0;
                     o_mem_en   <= 1'b1;
                     o_mem_addr <= '0;
                  end
               end
            end

            StFetch: begin
               o_mem_en <= 1'b0;
               state    <= StApply;
            end

            StApply: begin
               o_dut_in <= stim_field;
               exp_q    <= exp_field;
               state    <= (DUT_LAT > 0) ? StWait : StCheck;
            end

            StWait: begin
               if (wait_done) begin
                  state <= StCheck;
               end
            end

            StCheck: begin
               if (mismatch) begin
                  o_err_count <= err_next;
                  if (o_err_count == '0) begin
                     o_fail_index <= index;
                  end
               end
               if (finish_run) begin
                  state  <= StDone;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  o_pass <= !mismatch && (o_err_count == '0);
               end else begin
                  index      <= index + 1'b1;
                  o_mem_addr <= index + 1'b1;
                  o_mem_en   <= 1'b1;
                  state      <= StFetch;
               end
            end

            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tv_sequencer.sv
// Directed bench for tv_sequencer: vector ROM model with one-cycle read latency
// and a loopback register acting as a DUT_LAT=1 device under test.
// Cycle numbering: the cycle in which i_start is sampled is cycle 0.
module tb_tv_sequencer;
   import tv_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  num_vectors;
   logic        mem_en;
   logic [6:0]  mem_addr;
   logic [15:0] mem_data;
   logic [7:0]  dut_in;
   logic [7:0]  dut_out;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [6:0]  fail_index;

   tv_word_s    rom [128];
   int          fetch_cnt  = 0;
   int          addr3_cnt  = 0;
   logic [6:0]  last_addr  = '0;
   int          n_cmp      = 0;
   int          n_mis      = 0;

   always #5 clk = ~clk;

   tv_sequencer #(
      .IN_W    (8),
      .OUT_W   (8),
      .DEPTH   (128),
      .DUT_LAT (1),
      .ERR_W   (16)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_start       (start),
      .i_num_vectors (num_vectors),
      .o_mem_en      (mem_en),
      .o_mem_addr    (mem_addr),
      .i_mem_data    (mem_data),
      .o_dut_in      (dut_in),
      .i_dut_out     (dut_out),
      .o_busy        (busy),
      .o_done        (done),
      .o_pass        (pass),
      .o_err_count   (err_count),
      .o_fail_index  (fail_index)
   );

   always @(posedge clk) begin
      if (mem_en) mem_data <= rom[mem_addr];
      dut_out <= dut_in;
   end

   always @(negedge clk) begin
      if (mem_en) begin
         fetch_cnt++;
         last_addr = mem_addr;
         if (mem_addr == 7'd3) addr3_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Starts a run and returns the cycle in which done is first seen (-1 on
   // timeout). poke_at>0 injects a reset or a start(num=1) pulse in that cycle;
   // a reset poke returns in the cycle right after it was sampled.
   task automatic run_vec(input logic [7:0] num, input int poke_at, input bit poke_rst,
                          output int cycles);
      @(negedge clk);
      num_vectors = num;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cycles = 1;
      if (num != 8'd0) check_eq("busy_after_start", busy, 1);
      while (!done && cycles < 2000) begin
         if (cycles == poke_at) begin
            if (poke_rst) reset = 1'b1;
            else begin
               start       = 1'b1;
               num_vectors = 8'd1;
            end
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         reset = 1'b0;
         if (poke_rst && cycles == poke_at) begin
            cycles++;
            return;
         end
         cycles++;
      end
      if (!done) cycles = -1;
   endtask

   int cyc;
   int f0;
   int a0;
   int err_cycles;
   logic [7:0] v;

   initial begin
`ifdef TV_SEQ_STOP_ON_ERR_EN
      err_cycles = 13;
`else
      err_cycles = 17;
`endif
      for (int i = 0; i < 128; i++) begin
         v      = 8'(i * 3 + 5);
         rom[i] = '{stim: v, exp: v};
      end
      reset       = 1'b1;
      start       = 1'b0;
      num_vectors = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_pass", pass, 0);
      check_eq("rst_err", err_count, 0);
      check_eq("rst_fail_idx", fail_index, 0);
      check_eq("rst_dut_in", dut_in, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_mem_addr", mem_addr, 0);

      // Four matching vectors
      f0 = fetch_cnt;
      run_vec(8'd4, 0, 1'b0, cyc);
      check_eq("pass4_cycles", cyc, 17);
      check_eq("pass4_err", err_count, 0);
      check_eq("pass4_pass", pass, 1);
      check_eq("pass4_busy", busy, 0);
      check_eq("pass4_fetches", fetch_cnt - f0, 4);
      check_eq("pass4_dut_in_hold", dut_in, 8'h0E);

      // Vector 2 mismatches
      rom[2] = '{stim: 8'h12, exp: 8'hFF};
      f0 = fetch_cnt;
      a0 = addr3_cnt;
      run_vec(8'd4, 0, 1'b0, cyc);
      check_eq("err_cycles", cyc, err_cycles);
      check_eq("err_count", err_count, 1);
      check_eq("err_fail_idx", fail_index, 2);
      check_eq("err_pass", pass, 0);
      check_eq("err_done", done, 1);
`ifdef TV_SEQ_STOP_ON_ERR_EN
      check_eq("err_addr3_fetch", addr3_cnt - a0, 0);
      check_eq("err_fetches", fetch_cnt - f0, 3);
`else
      check_eq("err_addr3_fetch", addr3_cnt - a0, 1);
      check_eq("err_fetches", fetch_cnt - f0, 4);
`endif

      // Empty run
      f0 = fetch_cnt;
      run_vec(8'd0, 0, 1'b0, cyc);
      check_eq("zero_cycles", cyc, 1);
      check_eq("zero_pass", pass, 1);
      check_eq("zero_busy", busy, 0);
      check_eq("zero_err", err_count, 0);
      check_eq("zero_fetches", fetch_cnt - f0, 0);

      // Reset during vector 1 WAIT, then a clean rerun from index 0
      run_vec(8'd4, 7, 1'b1, cyc);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_done", done, 0);
      check_eq("midrst_mem_en", mem_en, 0);
      check_eq("midrst_dut_in", dut_in, 0);
      check_eq("midrst_pass", pass, 0);
      f0 = fetch_cnt;
      run_vec(8'd4, 0, 1'b0, cyc);
      check_eq("rerun_cycles", cyc, err_cycles);
      check_eq("rerun_err", err_count, 1);
      check_eq("rerun_fail_idx", fail_index, 2);

      // Request beyond DEPTH is clamped
      rom[2] = '{stim: 8'h0B, exp: 8'h0B};
      f0 = fetch_cnt;
      run_vec(8'd200, 0, 1'b0, cyc);
      check_eq("clamp_cycles", cyc, 513);
      check_eq("clamp_fetches", fetch_cnt - f0, 128);
      check_eq("clamp_last_addr", last_addr, 127);
      check_eq("clamp_pass", pass, 1);

      // Start during vector 0 CHECK is ignored
      f0 = fetch_cnt;
      run_vec(8'd4, 4, 1'b0, cyc);
      check_eq("busystart_cycles", cyc, 17);
      check_eq("busystart_fetches", fetch_cnt - f0, 4);
      check_eq("busystart_pass", pass, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
